// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM states, store lane helper and access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } store_lanes_t;

  // Byte enables and lane-replicated data for a store of the given width.
  function automatic store_lanes_t store_lanes(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] wdata);
    store_lanes_t s;
    case (f3)
      F3_B: begin
        s.mask = 4'b0001 << off;
        s.data = {4{wdata[7:0]}};
      end
      F3_H: begin
        s.mask = 4'b0011 << off;
        s.data = {2{wdata[15:0]}};
      end
      F3_W: begin
        s.mask = 4'b1111;
        s.data = wdata;
      end
      default: begin
        s.mask = 4'b0000;
        s.data = 32'h0000_0000;
      end
    endcase
    return s;
  endfunction

  // 1 when the funct3 code is legal for the direction and the offset is aligned.
  function automatic logic access_legal(input logic       write,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = (off[0] == 1'b0);
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = !write;
      F3_HU:   ok = !write && (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the addressed bytes of a read word down to bit 0 and extends them
// according to the load width/sign code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // Lane select followed by sign or zero extension.
  always_comb begin
    shifted_s = rdata >> {off, 3'b000};
    result    = 32'h0000_0000;
    case (funct3)
      F3_B:    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    result = rdata;
      F3_BU:   result = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   result = {16'h0000, shifted_s[15:0]};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator: accepts one RV32I access per handshake, drives a
// word-aligned data-memory access held for ACCESS_CYCLES, and returns
// aligned/extended load data or an error over a valid/ready response.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_addr,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned   CW       = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  lsu_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic         write_r;
  logic [2:0]   f3_r;
  logic [1:0]   off_r;
  logic         ready_r, valid_r, err_r;
  logic [31:0]  rdata_r, addr_r, wdata_r;
  logic [3:0]   wmask_r;

  logic         accept_s, legal_s, last_s, resp_done_s;
  logic [31:0]  load_s;
  store_lanes_t lanes_s;

  assign accept_s    = req_valid && ready_r;
  assign resp_done_s = valid_r && resp_ready;
  assign last_s      = (cnt_r == {CW{1'b0}});
  assign legal_s     = access_legal(req_write, req_funct3, req_addr[1:0]);
  assign lanes_s     = store_lanes(req_funct3, req_addr[1:0], req_wdata);

  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .off    (off_r),
    .funct3 (f3_r),
    .result (load_s)
  );

  assign req_ready  = ready_r;
  assign resp_valid = valid_r;
  assign resp_rdata = rdata_r;
  assign resp_err   = err_r;
  assign dmem_addr  = addr_r;
  assign dmem_wmask = wmask_r;
  assign dmem_wdata = wdata_r;
  // Single commit cycle; gated by reset so an aborted access never writes.
  assign dmem_write = rst && write_r && (state_r == ACCESS) && last_s;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (legal_s) begin
            state_s = ACCESS;
          end else begin
            state_s = RESP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (last_s) begin
          state_s = RESP;
        end else begin
          state_s = ACCESS;
        end
      end
      RESP: begin
        if (resp_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, handshake flags, request latches, port and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
      write_r <= 1'b0;
      f3_r    <= 3'b000;
      off_r   <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wmask_r <= 4'b0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
      // Valid rises one cycle into RESP and drops on the handshake edge.
      valid_r <= (state_r == RESP) && !resp_done_s;
      if (accept_s) begin
        write_r <= req_write;
        f3_r    <= req_funct3;
        off_r   <= req_addr[1:0];
        rdata_r <= 32'h0000_0000;
        if (legal_s) begin
          cnt_r   <= CNT_LOAD;
          err_r   <= 1'b0;
          addr_r  <= {req_addr[31:2], 2'b00};
          wmask_r <= req_write ? lanes_s.mask : 4'b0000;
          wdata_r <= req_write ? lanes_s.data : wdata_r;
        end else begin
          err_r   <= 1'b1;
        end
      end else if (state_r == ACCESS) begin
        if (last_s) begin
          rdata_r <= write_r ? 32'h0000_0000 : load_s;
        end else begin
          cnt_r <= cnt_r - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: table-driven load/store vectors with a response
// scoreboard against ACCESS_CYCLES=1, plus hand sequences for response
// back-pressure and reset-abort of a slow (ACCESS_CYCLES=3) store.
module tb_dmem_lsu;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  exp_t sbq [$];
  vec_t vecs [23];

  // Instance 1: ACCESS_CYCLES = 1
  logic        rst, req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1, dmem_write1;
  logic [2:0]  req_funct31;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1, dmem_addr1, dmem_wdata1, dmem_rdata1;
  logic [3:0]  dmem_wmask1;
  logic [31:0] mem1 [0:255];
  int          wr_cnt1 = 0;
  logic [3:0]  last_mask1 = 4'h0;
  logic [31:0] last_wdata1 = 32'h0;

  // Instance 3: ACCESS_CYCLES = 3
  logic        rst3, req_valid3, req_ready3, req_write3, resp_valid3, resp_ready3, resp_err3, dmem_write3;
  logic [2:0]  req_funct33;
  logic [31:0] req_addr3, req_wdata3, resp_rdata3, dmem_addr3, dmem_wdata3, dmem_rdata3;
  logic [3:0]  dmem_wmask3;
  logic [31:0] mem3 [0:255];
  int          wr_cnt3 = 0;

  dmem_lsu #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_funct3(req_funct31), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1), .dmem_addr(dmem_addr1),
    .dmem_write(dmem_write1), .dmem_wmask(dmem_wmask1), .dmem_wdata(dmem_wdata1),
    .dmem_rdata(dmem_rdata1)
  );

  dmem_lsu #(.ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_funct3(req_funct33), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_rdata(resp_rdata3), .resp_err(resp_err3), .dmem_addr(dmem_addr3),
    .dmem_write(dmem_write3), .dmem_wmask(dmem_wmask3), .dmem_wdata(dmem_wdata3),
    .dmem_rdata(dmem_rdata3)
  );

  assign dmem_rdata1 = mem1[dmem_addr1[9:2]];
  assign dmem_rdata3 = mem3[dmem_addr3[9:2]];

  // Behavioural memories: preload during global reset, byte-masked writes.
  always @(posedge clk) begin
    if (!rst) begin
      mem1[8'h40] <= 32'h8899_AABB;
      mem3[8'h80] <= 32'h0123_4567;
    end else begin
      if (dmem_write1)
        for (int b = 0; b < 4; b++)
          if (dmem_wmask1[b]) mem1[dmem_addr1[9:2]][8*b +: 8] <= dmem_wdata1[8*b +: 8];
      if (dmem_write3)
        for (int b = 0; b < 4; b++)
          if (dmem_wmask3[b]) mem3[dmem_addr3[9:2]][8*b +: 8] <= dmem_wdata3[8*b +: 8];
    end
  end

  // Write strobe monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (dmem_write1) begin
      wr_cnt1     <= wr_cnt1 + 1;
      last_mask1  <= dmem_wmask1;
      last_wdata1 <= dmem_wdata1;
    end
    if (dmem_write3) wr_cnt3 <= wr_cnt3 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request into dut1, score its response and port activity.
  task automatic run_vec(input vec_t v, output int acc_wait);
    int   base, lat;
    logic [31:0] mem_before;
    exp_t e;
    base       = wr_cnt1;
    mem_before = mem1[v.addr[9:2]];
    req_valid1 = 1'b1; req_write1 = v.write; req_funct31 = v.f3;
    req_addr1  = v.addr; req_wdata1 = v.wdata;
    acc_wait = 0;
    while (!req_ready1 && acc_wait < 20) begin @(posedge clk); #1; acc_wait++; end
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    sbq.push_back('{v.exp_rdata, v.exp_err});
    lat = 0;
    while (!resp_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), v.exp_err ? 32'd1 : 32'd2);
    if (resp_valid1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("resp_rdata", resp_rdata1, e.rdata);
      chk("resp_err", {31'd0, resp_err1}, {31'd0, e.err});
      resp_ready1 = 1'b1;
      @(posedge clk); #1;
      resp_ready1 = 1'b0;
    end
    chk("write_count", 32'(wr_cnt1 - base), (v.write && !v.exp_err) ? 32'd1 : 32'd0);
    if (v.write && !v.exp_err) begin
      chk("wmask", {28'd0, last_mask1}, {28'd0, v.exp_mask});
      chk("wdata", last_wdata1, v.exp_wdata);
    end
    if (v.exp_err) chk("mem_unchanged", mem1[v.addr[9:2]], mem_before);
    chk("ready_after_resp", {31'd0, req_ready1}, 32'd1);
  endtask

  initial begin
    int w, lat, base;
    vecs[0]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFF_FFAA, 1'b0, 4'h0,    32'h0};
    vecs[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h0000_0088, 1'b0, 4'h0,    32'h0};
    vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF_8899, 1'b0, 4'h0,    32'h0};
    vecs[3]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h0000_AABB, 1'b0, 4'h0,    32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8899_AABB, 1'b0, 4'h0,    32'h0};
    vecs[5]  = '{1'b1, 3'b000, 32'h102, 32'h1122_3344, 32'h0,        1'b0, 4'b0100, 32'h4444_4444};
    vecs[6]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8844_AABB, 1'b0, 4'h0,    32'h0};
    vecs[7]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,         1'b1, 4'h0,    32'h0};
    vecs[8]  = '{1'b1, 3'b001, 32'h101, 32'h5555_6666, 32'h0,        1'b1, 4'h0,    32'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,         1'b1, 4'h0,    32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h100, 32'h7777_7777, 32'h0,        1'b1, 4'h0,    32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h102, 32'h0000_CAFE, 32'h0,        1'b0, 4'b1100, 32'hCAFE_CAFE};
    vecs[12] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hCAFE_AABB, 1'b0, 4'h0,    32'h0};
    vecs[13] = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFF_FFCA, 1'b0, 4'h0,    32'h0};
    vecs[14] = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h0000_CAFE, 1'b0, 4'h0,    32'h0};
    vecs[15] = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h0,         1'b1, 4'h0,    32'h0};
    vecs[16] = '{1'b1, 3'b010, 32'h100, 32'h1234_5678, 32'h0,        1'b0, 4'b1111, 32'h1234_5678};
    vecs[17] = '{1'b0, 3'b000, 32'h100, 32'h0,        32'h0000_0078, 1'b0, 4'h0,    32'h0};
    vecs[18] = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h0000_0056, 1'b0, 4'h0,    32'h0};
    vecs[19] = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h0000_5678, 1'b0, 4'h0,    32'h0};
    vecs[20] = '{1'b0, 3'b110, 32'h100, 32'h0,        32'h0,         1'b1, 4'h0,    32'h0};
    vecs[21] = '{1'b0, 3'b111, 32'h100, 32'h0,        32'h0,         1'b1, 4'h0,    32'h0};
    vecs[22] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h1234_5678, 1'b0, 4'h0,    32'h0};

    rst = 1'b0; rst3 = 1'b0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_funct31 = 3'b000; req_addr1 = 32'h0; req_wdata1 = 32'h0; resp_ready1 = 1'b0;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_funct33 = 3'b000; req_addr3 = 32'h0; req_wdata3 = 32'h0; resp_ready3 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready1}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid1}, 32'd0);
    chk("rst_resp_rdata", resp_rdata1, 32'd0);
    chk("rst_dmem_addr", dmem_addr1, 32'd0);
    chk("rst_dmem_wmask", {28'd0, dmem_wmask1}, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata1, 32'd0);
    rst = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, req_ready1}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 23; i++) run_vec(vecs[i], w);

    // Response back-pressure, then a back-to-back request
    req_valid1 = 1'b1; req_write1 = 1'b0; req_funct31 = 3'b010; req_addr1 = 32'h100;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    lat = 0;
    while (!resp_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("stall_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, resp_valid1}, 32'd1);
      chk("stall_rdata", resp_rdata1, 32'h1234_5678);
      chk("stall_err", {31'd0, resp_err1}, 32'd0);
      chk("stall_req_ready", {31'd0, req_ready1}, 32'd0);
    end
    resp_ready1 = 1'b1;
    @(posedge clk); #1;
    resp_ready1 = 1'b0;
    chk("stall_resp_drop", {31'd0, resp_valid1}, 32'd0);
    run_vec('{1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0012, 1'b0, 4'h0, 32'h0}, w);
    chk("back_to_back_wait", 32'(w), 32'd0);

    // Slow store aborted by reset in the 2nd, then the final, ACCESS cycle
    for (int k = 1; k <= 2; k++) begin
      base = wr_cnt3;
      @(posedge clk); #1;
      req_valid3 = 1'b1; req_write3 = 1'b1; req_funct33 = 3'b010;
      req_addr3 = 32'h200; req_wdata3 = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      chk("abort_accepted", {31'd0, req_ready3}, 32'd0);
      repeat (k) @(posedge clk);
      #1;
      rst3 = 1'b0;
      #1;
      chk("abort_write_gated", {31'd0, dmem_write3}, 32'd0);
      @(posedge clk); #1;
      chk("abort_ready_in_rst", {31'd0, req_ready3}, 32'd0);
      chk("abort_resp_valid", {31'd0, resp_valid3}, 32'd0);
      chk("abort_wmask", {28'd0, dmem_wmask3}, 32'd0);
      rst3 = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready_after", {31'd0, req_ready3}, 32'd1);
      chk("abort_no_write", 32'(wr_cnt3 - base), 32'd0);
      chk("abort_mem", mem3[8'h80], 32'h0123_4567);
      req_valid3 = 1'b1; req_write3 = 1'b0; req_funct33 = 3'b010; req_addr3 = 32'h200;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      lat = 0;
      while (!resp_valid3 && lat < 30) begin @(posedge clk); #1; lat++; end
      chk("slow_latency", 32'(lat), 32'd4);
      chk("slow_rdata", resp_rdata3, 32'h0123_4567);
      chk("slow_err", {31'd0, resp_err3}, 32'd0);
      resp_ready3 = 1'b1;
      @(posedge clk); #1;
      resp_ready3 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that sits between the core's memory stage and the byte-addressed data-memory port (dmem_addr/dmem_write/dmem_wmask/dmem_wdata/dmem_rdata).
- Accepts one RV32I load or store per handshake and drives a word-aligned port access.
- Aligns and extends load data, and returns a response over a valid/ready handshake.
- Is the requesting end of the data port, both in simulation against the behavioural memory and in synthesis.

Parameters:
ACCESS_CYCLES, 1, cycles the port access is held before read data is sampled (≥1); models slower memory.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  in  32  byte address
req_wdata  in  32  store data, low-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal funct3
dmem_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
dmem_write  out  1  write strobe
dmem_wmask  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid during ACCESS

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst=0 at a clock edge):
  - Next state is IDLE.
  - req_ready=0 while rst=0, then 1 from the first cycle after reset releases.
  - resp_valid=0, resp_err=0, resp_rdata=0, dmem_addr=0, dmem_wmask=0, dmem_wdata=0, wait counter=0.
  - dmem_write is combinationally gated with rst, so no write commits at any edge where rst=0. A reset mid-ACCESS aborts without a memory update.
- req_ready=1 only in IDLE. Exactly one transaction is outstanding.
- IDLE, on req_valid & req_ready: latch write, funct3, addr, wdata, and the byte offset off=addr[1:0]. Then check legality:
  - Illegal if funct3 is 011/110/111 on a load, or >010 on a store.
  - Misaligned if an H access has off[0]=1, or a W access has off≠0.
  - If illegal or misaligned: go to RESP with resp_err=1, resp_rdata=0. No ACCESS, and port outputs are not updated.
  - Otherwise go to ACCESS and load the counter with ACCESS_CYCLES-1.
- ACCESS:
  - Port outputs are registered and stable for the whole state.
  - Write mask: SB = 0001<<off, SH = 0011<<off, SW = 1111. Loads drive mask 0000.
  - Write data: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
  - dmem_write=1 only in the final ACCESS cycle (counter==0) and only for stores, giving a single commit edge.
  - On counter==0, go to RESP. For loads, register the result: shift dmem_rdata right by 8*off, take 8 or 16 bits, sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through. Stores return 0.
- Load latency: request accepted at edge N, resp_valid high from edge N+1+ACCESS_CYCLES.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready=1.
  - On resp_valid & resp_ready, go to IDLE. The next request cannot be accepted until the following cycle, so there is no bypass.
- dmem_addr keeps its last value outside ACCESS. dmem_write=0 outside ACCESS.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_t {IDLE, ACCESS, RESP}.
  - A function for the store mask/replication.
- One sub-module, lsu_load_align: combinational; inputs rdata, off, and funct3; output is the 32-bit extended result.

Test Plan:
- Preload bytes 0x100..0x103 = BB AA 99 88. LB @0x101 -> resp_rdata 0xFFFFFFAA, err 0, resp_valid exactly 2 cycles after accept (ACCESS_CYCLES=1).
- LBU @0x103 -> 0x00000088. LH @0x102 -> 0xFFFF8899. LHU @0x100 -> 0x0000AABB. LW @0x100 -> 0x8899AABB.
- SB @0x102, wdata 0x11223344:
  - Required port values: dmem_wmask 0100, dmem_wdata 0x44444444, dmem_write high exactly 1 cycle.
  - A following LW @0x100 -> 0x8844AABB.
- LW @0x102, SH @0x101, and a load with funct3 011 -> each gives resp_err=1, rdata 0, dmem_write never asserted, memory unchanged.
- SW @0x200 wdata 0xDEADBEEF with ACCESS_CYCLES=3, rst driven 0 during the 2nd ACCESS cycle:
  - Required: no dmem_write.
  - After reset, LW @0x200 returns its original contents; req_ready=1 the cycle after rst returns to 1.
- LW with resp_ready held 0 for 4 cycles -> resp_valid, resp_rdata, and resp_err stable throughout, and req_ready=0. Assert resp_ready -> IDLE next cycle, and a back-to-back request is accepted one cycle later.
